// File: rtl/ram_arbiter2.sv
// ============================================================================
// Module      : ram_arbiter2
// Description : Two-requester round-robin arbiter with a full-RAM clear engine
//               in front of a single-port RAM (asynchronous read, sync write).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter2 #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = '1;

    state_t                state_q, state_d;
    logic                  prio_q, prio_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rvalid0_q, rvalid0_d;
    logic                  rvalid1_q, rvalid1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  clear_done_q, clear_done_d;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        cnt_d        = cnt_q;
        rvalid0_d    = 1'b0;
        rvalid1_d    = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        clear_done_d = 1'b0;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        clear_busy   = 1'b0;
        mem_address  = '0;
        mem_wdata    = '0;
        mem_write    = 1'b0;

        // Outputs stay quiet while reset is asserted, regardless of state.
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (clear_start) begin
                        state_d = S_CLEAR;
                        cnt_d   = '0;
                    end else if (req0 && (!req1 || !prio_q)) begin
                        gnt0 = 1'b1;
                    end else if (req1) begin
                        gnt1 = 1'b1;
                    end

                    if (gnt0) begin
                        mem_address = addr0;
                        mem_wdata   = wdata0;
                        mem_write   = we0;
                        prio_d      = 1'b1;
                        if (!we0) begin
                            rvalid0_d = 1'b1;
                            rdata0_d  = mem_rdata;
                        end
                    end else if (gnt1) begin
                        mem_address = addr1;
                        mem_wdata   = wdata1;
                        mem_write   = we1;
                        prio_d      = 1'b0;
                        if (!we1) begin
                            rvalid1_d = 1'b1;
                            rdata1_d  = mem_rdata;
                        end
                    end
                end

                S_CLEAR: begin
                    clear_busy  = 1'b1;
                    mem_address = cnt_q;
                    mem_write   = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == C_LAST_ADDR) begin
                        state_d      = S_IDLE;
                        cnt_d        = '0;
                        clear_done_d = 1'b1;
                    end
                end

                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            cnt_q        <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            cnt_q        <= cnt_d;
            rvalid0_q    <= rvalid0_d;
            rvalid1_q    <= rvalid1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    assign rdata0     = rdata0_q;
    assign rdata1     = rdata1_q;
    assign clear_done = clear_done_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter2.sv
// ============================================================================
// Module      : tb_ram_arbiter2
// Description : Scoreboard bench for ram_arbiter2 with a behavioural 1024x32 RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, we0, req1, we1;
    logic [9:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic        clear_start, clear_busy, clear_done;
    logic [9:0]  mem_address;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;

    logic [31:0] ram [1024] = '{default: 32'h0};
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_write) ram[mem_address] <= mem_wdata;
    assign mem_rdata = ram[mem_address];

    ram_arbiter2 #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Push the expected read data for the requester granted this cycle.
    task automatic push_exp(input int r, input logic [31:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        if (r == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic acc(input int r, input logic w, input logic [9:0] a,
                       input logic [31:0] d, input logic [31:0] exp);
        int   n;
        logic g;
        n = 0;
        if (r == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        @(negedge clk);
        g = (r == 0) ? gnt0 : gnt1;
        while (!g && n < 2000) begin
            @(posedge clk); #1;
            @(negedge clk);
            g = (r == 0) ? gnt0 : gnt1;
            n++;
        end
        chk("gnt_wait", {31'd0, g}, 32'd1);
        if (g && !w) push_exp(r, exp);
        @(posedge clk); #1;
        if (r == 0) req0 = 1'b0;
        else        req1 = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    initial begin
        int busy, bad, dones;
        exp_t e;

        rst_n = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 10'd3; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; clear_start = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rvalid0) begin
                    if (q0.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rvalid0_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = q0.pop_front();
                        chk("rdata0", rdata0, e.data);
                        chk("rvalid0_cycle", cyc, e.cyc);
                    end
                end
                if (rvalid1) begin
                    if (q1.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rvalid1_unexpected: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        e = q1.pop_front();
                        chk("rdata1", rdata1, e.data);
                        chk("rvalid1_cycle", cyc, e.cyc);
                    end
                end
            end
        join_none

        // Reset state
        @(negedge clk);
        chk("rst_gnt0", {31'd0, gnt0}, 0);
        chk("rst_rvalid0", {31'd0, rvalid0}, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_busy", {31'd0, clear_busy}, 0);
        chk("rst_done", {31'd0, clear_done}, 0);
        chk("rst_mem_write", {31'd0, mem_write}, 0);
        chk("rst_mem_addr", {22'd0, mem_address}, 0);
        tick();
        rst_n = 1'b1; req0 = 1'b0;

        // Write then read back by requester 0
        acc(0, 1'b1, 10'd5, 32'hDEADBEEF, 0);
        acc(0, 1'b0, 10'd5, 0, 32'hDEADBEEF);
        acc(1, 1'b1, 10'd6, 32'h600D0006, 0);
        tick(); tick();

        // Contention from reset: grants alternate starting with requester 0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd5;
        req1 = 1'b1; we1 = 1'b0; addr1 = 10'd6;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("alt_gnt0", {31'd0, gnt0}, (i % 2 == 0) ? 1 : 0);
            chk("alt_gnt1", {31'd0, gnt1}, (i % 2 == 1) ? 1 : 0);
            if (gnt0) push_exp(0, 32'hDEADBEEF);
            if (gnt1) push_exp(1, 32'h600D0006);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Requester 1 alone three times, then requester 0 wins contention
        req1 = 1'b1; we1 = 1'b1; addr1 = 10'd200; wdata1 = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("solo_gnt1", {31'd0, gnt1}, 1);
            tick();
        end
        addr1 = 10'd512; wdata1 = 32'hB5120000;
        req0 = 1'b1; we0 = 1'b1; addr0 = 10'd0; wdata0 = 32'hA0A0A0A0;
        @(negedge clk);
        chk("cont_gnt0", {31'd0, gnt0}, 1);
        chk("cont_gnt1", {31'd0, gnt1}, 0);
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("cont_next_gnt1", {31'd0, gnt1}, 1);
        tick(); req1 = 1'b0;
        acc(0, 1'b1, 10'd1023, 32'hC0DE1023, 0);
        acc(1, 1'b0, 10'd0, 0, 32'hA0A0A0A0);
        acc(1, 1'b0, 10'd200, 0, 32'h1234);
        // Read-after-write by the other requester on the next cycle
        acc(0, 1'b1, 10'd7, 32'h77777777, 0);
        acc(1, 1'b0, 10'd7, 0, 32'h77777777);
        tick();

        // Clear wins over a pending request; second start is ignored
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'd0; clear_start = 1'b1;
        @(negedge clk);
        chk("clear_blocks_gnt0", {31'd0, gnt0}, 0);
        tick(); clear_start = 1'b0;
        busy = 0; bad = 0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (!clear_busy) break;
            if (int'(mem_address) != busy || !mem_write || gnt0 || mem_wdata != 0 || clear_done) bad++;
            busy++;
            tick();
            clear_start = (busy == 10);
        end
        clear_start = 1'b0;
        chk("clear_busy_len", busy, 1024);
        chk("clear_sweep_bad", bad, 0);
        chk("clear_done_pulse", {31'd0, clear_done}, 1);
        chk("post_clear_gnt0", {31'd0, gnt0}, 1);
        if (gnt0) push_exp(0, 32'h0);
        tick(); req0 = 1'b0;
        @(negedge clk);
        chk("clear_done_single", {31'd0, clear_done}, 0);
        tick();
        acc(0, 1'b0, 10'd512, 0, 32'h0);
        acc(1, 1'b0, 10'd1023, 0, 32'h0);
        acc(1, 1'b0, 10'd7, 0, 32'h0);

        // Reset in the middle of a clear
        acc(0, 1'b1, 10'd200, 32'h1234, 0);
        acc(0, 1'b1, 10'd50, 32'h5050, 0);
        clear_start = 1'b1; tick(); clear_start = 1'b0;
        for (int i = 0; i < 99; i++) tick();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, clear_busy}, 0);
        chk("rst_mid_write", {31'd0, mem_write}, 0);
        tick(); rst_n = 1'b1;
        dones = 0; busy = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (clear_done) dones++;
            if (clear_busy) busy++;
            tick();
        end
        chk("rst_mid_no_done", dones, 0);
        chk("rst_mid_idle", busy, 0);
        acc(0, 1'b0, 10'd50, 0, 32'h0);
        acc(1, 1'b0, 10'd200, 0, 32'h1234);
        tick(); tick(); tick();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
